mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Sits directly downstream of the address-translation stage. Captures its two single-cycle request pulses:
//    - fetch: if_request + address1
//    - data:  mem_en + address2, plus store info
//  Serialises them onto one memory port using a valid/ready request and valid response handshake.
//  Returns read data and a one-cycle done pulse to the matching requester.
//  Provides a response-timeout watchdog with a sticky error flag.
// PARAMETERS
//  ADDR_W   64    request address width
//  DATA_W   64    data width; mask width is DATA_W/8
//  TIMEOUT  255   max cycles waiting for resp_valid before abort; 0 disables the watchdog
// PORTS
//  clk          in   1         clock; everything samples on posedge
//  rst          in   1         synchronous, active-high reset
//  if_request   in   1         fetch request pulse, 1 cycle
//  address1     in   ADDR_W    fetch address, valid with if_request
//  if_done      out  1         fetch complete pulse
//  if_rdata     out  DATA_W    fetch data, valid with if_done
//  mem_en       in   1         data request pulse, 1 cycle
//  address2     in   ADDR_W    data address, valid with mem_en
//  d_we         in   1         data request is a store, valid with mem_en
//  d_wdata      in   DATA_W    store data
//  d_wmask      in   DATA_W/8  store byte mask
//  d_done       out  1         data complete pulse (load or store)
//  d_rdata      out  DATA_W    load data, valid with d_done
//  req_valid    out  1         memory request valid
//  req_ready    in   1         memory accepts the request
//  req_addr     out  ADDR_W    memory address
//  req_we       out  1         memory write enable
//  req_wdata    out  DATA_W    memory write data
//  req_wmask    out  DATA_W/8  memory byte mask
//  resp_valid   in   1         memory response valid
//  resp_rdata   in   DATA_W    memory read data
//  overrun      out  1         sticky: a pulse arrived while its port was already pending
//  timeout_err  out  1         sticky: watchdog fired
// BEHAVIOUR
//  Reset values:
//    - All outputs, pending flags and latched fields are 0; state is IDLE.
//    - Reset mid-transaction drops the transaction; no done pulse is issued.
//  Capture:
//    - An input pulse sets that port's pending bit and latches its address (and store fields) the same edge.
//    - A pulse on an already-pending port is dropped. The latched fields are kept and overrun is set.
//    - A pulse arriving in the same cycle as that port's done pulse is accepted as a new request.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE
//    - IDLE: if any port is pending, select it and go to ISSUE. Data beats fetch, since data is the older instruction.
//      Selection uses the registered pending bits; a pulse arriving in IDLE is served no earlier than the next cycle.
//    - ISSUE: drive req_valid=1 with the selected fields, held stable until req_ready. On req_valid&&req_ready go to WAIT.
//    - WAIT: on resp_valid, pulse the matching done for one cycle with rdata = resp_rdata.
//      Clear that pending bit (unless a new pulse re-sets it the same edge) and go to IDLE.
//  Stores:
//    - d_done fires on resp_valid exactly like a load; d_rdata is don't-care.
//  Watchdog:
//    - The counter resets on entry to WAIT.
//    - At TIMEOUT cycles without resp_valid: set timeout_err, clear the pending bit, return to IDLE, no done pulse.
//  Ignored inputs:
//    - resp_valid outside WAIT is ignored.
//    - req_ready outside ISSUE is ignored.
//  Latency:
//    - Pulse at cycle N -> req_valid at N+2 at the earliest.
//    - Done pulse one cycle after resp_valid is sampled.
//  if_rdata / d_rdata hold their last value between done pulses.
// STRUCTURE
//  Shared package (mem_pkg):
//    - arb_state_e enum {IDLE, ISSUE, WAIT}
//    - mem_req_t struct {addr, we, wdata, wmask}
//    - ADDR_W / DATA_W defaults
//  One sub-module, req_slot: pending bit + latched mem_req_t + overrun detect, instantiated twice (fetch, data).
//  FSM, selection mux and watchdog counter live in the top.
// TESTING
//  1. Fetch pulse addr 0x8000_0000, req_ready=1 immediately, resp 3 cycles later with 0xDEAD
//     -> req_addr=0x8000_0000, req_we=0; one if_done with if_rdata=0xDEAD.
//  2. if_request and mem_en in the same cycle (0x1000 / store 0x2000, wdata 0x55, mask 0x01)
//     -> data request issued first with we=1, mask=0x01; fetch issued after d_done; each done pulses once.
//  3. req_ready held low 5 cycles
//     -> req_valid and all fields stable for 6 cycles; a single handshake.
//  4. Second mem_en while the first is pending (addr 0x3000 then 0x4000)
//     -> only 0x3000 issued; overrun=1 and stays 1.
//  5. TIMEOUT=4, no resp_valid
//     -> timeout_err=1 after 4 WAIT cycles; no done pulse; a later fetch completes normally.
//  6. rst asserted during WAIT, then a stale resp_valid
//     -> no done pulse; all outputs 0; state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory request arbiter: FSM states, the latched request
// record and default bus widths.
package mem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Memory-side request/response port: valid/ready request channel plus a
// valid-only response channel.
interface mem_req_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_we;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wmask;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/mem_req_arbiter_req_slot.sv
// One requester's capture slot: pending bit, latched request and sticky
// overrun flag for a pulse that arrives while the slot is still occupied.
module req_slot
  import mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     pulse,
  input  mem_req_t req_in,
  input  logic     clear,
  output logic     pending,
  output mem_req_t req,
  output logic     overrun
);

  // A clear on the same edge frees the slot, so a simultaneous pulse is taken as new work.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      req     <= '0;
      overrun <= 1'b0;
    end else begin
      if (pulse && (!pending || clear)) begin
        pending <= 1'b1;
        req     <= req_in;
      end else if (clear) begin
        pending <= 1'b0;
      end
      if (pulse && pending && !clear) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises fetch and data requests onto a single memory port, returns the
// response to the matching requester and guards the response with a watchdog.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int DATA_W  = mem_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_request,
  input  logic [ADDR_W-1:0]   address1,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_en,
  input  logic [ADDR_W-1:0]   address2,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  mem_req_arbiter_if.master   mem,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e       state;
  logic             sel_data;
  logic [CNT_W-1:0] wd_cnt;

  logic     f_pending, d_pending, f_overrun, d_overrun;
  mem_req_t f_in, d_in, f_req, d_req, pick;
  logic     wd_fire, txn_end;

  assign f_in = '{addr: address1, we: 1'b0, wdata: '0, wmask: '0};
  assign d_in = '{addr: address2, we: d_we, wdata: d_wdata, wmask: d_wmask};

  assign wd_fire = (TIMEOUT != 0) && (state == WAIT) && !mem.resp_valid && (wd_cnt == WD_LAST);
  assign txn_end = (state == WAIT) && (mem.resp_valid || wd_fire);
  assign pick    = d_pending ? d_req : f_req;
  assign overrun = f_overrun | d_overrun;

  req_slot u_fetch_slot (
    .clk     (clk),
    .rst     (rst),
    .pulse   (if_request),
    .req_in  (f_in),
    .clear   (txn_end && !sel_data),
    .pending (f_pending),
    .req     (f_req),
    .overrun (f_overrun)
  );

  req_slot u_data_slot (
    .clk     (clk),
    .rst     (rst),
    .pulse   (mem_en),
    .req_in  (d_in),
    .clear   (txn_end && sel_data),
    .pending (d_pending),
    .req     (d_req),
    .overrun (d_overrun)
  );

  // Data wins arbitration because it belongs to the older instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_data      <= 1'b0;
      wd_cnt        <= '0;
      mem.req_valid <= 1'b0;
      mem.req_addr  <= '0;
      mem.req_we    <= 1'b0;
      mem.req_wdata <= '0;
      mem.req_wmask <= '0;
      if_done       <= 1'b0;
      d_done        <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_pending || f_pending) begin
            sel_data      <= d_pending;
            mem.req_valid <= 1'b1;
            mem.req_addr  <= pick.addr;
            mem.req_we    <= pick.we;
            mem.req_wdata <= pick.wdata;
            mem.req_wmask <= pick.wmask;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem.req_ready) begin
            mem.req_valid <= 1'b0;
            wd_cnt        <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem.resp_valid) begin
            if (sel_data) begin
              d_done  <= 1'b1;
              d_rdata <= mem.resp_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem.resp_rdata;
            end
            state <= IDLE;
          end else if (wd_fire) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios followed by a
// randomised run, all judged against a cycle-level protocol model.
module tb_mem_req_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_request, mem_en, d_we;
  logic [63:0] address1, address2, d_wdata;
  logic [7:0]  d_wmask;
  logic        if_done, d_done, overrun, timeout_err;
  logic [63:0] if_rdata, d_rdata;

  mem_req_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mem ();

  mem_req_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_request  (if_request),
    .address1    (address1),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .mem_en      (mem_en),
    .address2    (address2),
    .d_we        (d_we),
    .d_wdata     (d_wdata),
    .d_wmask     (d_wmask),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .mem         (mem),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Protocol model: port 0 = fetch, port 1 = data.
  int          cyc;
  bit          pend [2];
  int          acc_cyc [2];
  logic [63:0] lat_addr [2];
  logic [63:0] lat_wdata [2];
  logic        lat_we [2];
  logic [7:0]  lat_wmask [2];
  bit          issuing, waiting;
  int          cur_port, wait_cnt, free_cyc;
  logic [63:0] cur_addr, cur_wdata;
  logic        cur_we;
  logic [7:0]  cur_wmask;
  bit          exp_if_done, exp_d_done, exp_overrun, exp_tmo, d_rdata_known;
  logic [63:0] exp_if_rdata, exp_d_rdata;
  int          n_if_done, n_d_done, n_rv_cycles;
  logic [63:0] hs_addr [$];
  bit          hs_we [$];

  bit          nf, nd, nwe;
  logic [63:0] na1, na2, nwd;
  logic [7:0]  nwm;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s differs", tag);
    end
  endtask

  task automatic pulse_fetch(input logic [63:0] a);
    nf  = 1'b1;
    na1 = a;
  endtask

  task automatic pulse_data(input logic [63:0] a, input bit we, input logic [63:0] wd, input logic [7:0] wm);
    nd  = 1'b1;
    na2 = a;
    nwe = we;
    nwd = wd;
    nwm = wm;
  endtask

  task automatic start_issue(input int p);
    issuing   = 1'b1;
    cur_port  = p;
    cur_addr  = lat_addr[p];
    cur_we    = lat_we[p];
    cur_wdata = lat_wdata[p];
    cur_wmask = lat_wmask[p];
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      if_request = 1'b0; mem_en = 1'b0; d_we = 1'b0;
      address1 = '0; address2 = '0; d_wdata = '0; d_wmask = '0;
      mem.req_ready = 1'b0; mem.resp_valid = 1'b0; mem.resp_rdata = '0;
      cyc++;
    end
    @(negedge clk);
    checkOutput("rst_if_done", if_done, 0);
    checkOutput("rst_d_done", d_done, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_req_valid", mem.req_valid, 0);
    checkOutput("rst_req_addr", mem.req_addr, 0);
    checkOutput("rst_req_we", mem.req_we, 0);
    checkOutput("rst_req_wdata", mem.req_wdata, 0);
    checkOutput("rst_req_wmask", mem.req_wmask, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    pend[0] = 0; pend[1] = 0;
    issuing = 0; waiting = 0; free_cyc = 0;
    exp_if_done = 0; exp_d_done = 0; exp_overrun = 0; exp_tmo = 0;
    exp_if_rdata = '0; exp_d_rdata = '0; d_rdata_known = 1;
    n_if_done = 0; n_d_done = 0; n_rv_cycles = 0;
    hs_addr.delete(); hs_we.delete();
    nf = 0; nd = 0;
  endtask

  // One clock cycle: drive queued pulses plus memory handshake, then judge outputs.
  task automatic applyStimulus(input bit rdy, input bit rv, input logic [63:0] rd);
    bit w;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_request = nf; address1 = na1;
    mem_en = nd; address2 = na2; d_we = nwe; d_wdata = nwd; d_wmask = nwm;
    mem.req_ready = rdy; mem.resp_valid = rv; mem.resp_rdata = rd;
    cyc++;
    @(negedge clk);
    checkOutput("if_done", if_done, exp_if_done);
    checkOutput("d_done", d_done, exp_d_done);
    checkOutput("if_rdata", if_rdata, exp_if_rdata);
    if (d_rdata_known) checkOutput("d_rdata", d_rdata, exp_d_rdata);
    checkOutput("overrun", overrun, exp_overrun);
    checkOutput("timeout_err", timeout_err, exp_tmo);
    n_if_done += int'(if_done);
    n_d_done  += int'(d_done);
    exp_if_done = 0;
    exp_d_done  = 0;

    w = waiting;
    if (!issuing && !w && cyc >= free_cyc) begin
      if (pend[1] && acc_cyc[1] <= cyc - 2) start_issue(1);
      else if (pend[0] && acc_cyc[0] <= cyc - 2) start_issue(0);
    end
    checkOutput("req_valid", mem.req_valid, issuing);
    if (issuing) begin
      n_rv_cycles++;
      checkOutput("req_addr", mem.req_addr, cur_addr);
      checkOutput("req_we", mem.req_we, cur_we);
      checkOutput("req_wdata", mem.req_wdata, cur_wdata);
      checkOutput("req_wmask", mem.req_wmask, cur_wmask);
    end

    if (w) begin
      wait_cnt++;
      if (rv) begin
        if (cur_port == 1) begin
          exp_d_done = 1;
          d_rdata_known = !cur_we;
          exp_d_rdata = rd;
        end else begin
          exp_if_done = 1;
          exp_if_rdata = rd;
        end
        pend[cur_port] = 0;
        waiting = 0;
        free_cyc = cyc + 2;
      end else if (wait_cnt == TB_TIMEOUT) begin
        exp_tmo = 1;
        pend[cur_port] = 0;
        waiting = 0;
        free_cyc = cyc + 2;
      end
    end

    if (issuing && rdy) begin
      issuing = 0;
      waiting = 1;
      wait_cnt = 0;
      hs_addr.push_back(cur_addr);
      hs_we.push_back(cur_we);
    end

    if (nf) begin
      if (pend[0]) exp_overrun = 1;
      else begin
        pend[0] = 1; acc_cyc[0] = cyc;
        lat_addr[0] = na1; lat_we[0] = 0; lat_wdata[0] = '0; lat_wmask[0] = '0;
      end
    end
    if (nd) begin
      if (pend[1]) exp_overrun = 1;
      else begin
        pend[1] = 1; acc_cyc[1] = cyc;
        lat_addr[1] = na2; lat_we[1] = nwe; lat_wdata[1] = nwd; lat_wmask[1] = nwm;
      end
    end
    nf = 0;
    nd = 0;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    if_request = 0; mem_en = 0; d_we = 0;
    address1 = '0; address2 = '0; d_wdata = '0; d_wmask = '0;
    mem.req_ready = 0; mem.resp_valid = 0; mem.resp_rdata = '0;
    nf = 0; nd = 0; nwe = 0; na1 = '0; na2 = '0; nwd = '0; nwm = '0;

    $display("[TB] single fetch");
    do_reset();
    pulse_fetch(64'h8000_0000);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, 64'hDEAD);
    applyStimulus(0, 0, '0);
    checkOutput("t1_hs_addr", hs_addr[0], 64'h8000_0000);
    checkOutput("t1_hs_we", hs_we[0], 0);
    checkOutput("t1_if_done_cnt", n_if_done, 1);
    checkOutput("t1_if_rdata", if_rdata, 64'hDEAD);

    $display("[TB] simultaneous fetch and store");
    do_reset();
    pulse_fetch(64'h1000);
    pulse_data(64'h2000, 1, 64'h55, 8'h01);
    applyStimulus(0, 0, '0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, {$urandom, $urandom});
    checkOutput("t2_hs_count", hs_addr.size(), 2);
    checkOutput("t2_first_addr", hs_addr[0], 64'h2000);
    checkOutput("t2_first_we", hs_we[0], 1);
    checkOutput("t2_second_addr", hs_addr[1], 64'h1000);
    checkOutput("t2_d_done_cnt", n_d_done, 1);
    checkOutput("t2_if_done_cnt", n_if_done, 1);

    $display("[TB] backpressure on req_ready");
    do_reset();
    pulse_fetch(64'hABC0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(0, 1, 64'h77);
    applyStimulus(0, 0, '0);
    checkOutput("t3_valid_cycles", n_rv_cycles, 6);
    checkOutput("t3_hs_count", hs_addr.size(), 1);

    $display("[TB] overrun on busy data port");
    do_reset();
    pulse_data(64'h3000, 0, '0, '0);
    applyStimulus(0, 0, '0);
    pulse_data(64'h4000, 0, '0, '0);
    applyStimulus(0, 0, '0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, {$urandom, $urandom});
    checkOutput("t4_hs_count", hs_addr.size(), 1);
    checkOutput("t4_hs_addr", hs_addr[0], 64'h3000);
    checkOutput("t4_overrun", overrun, 1);

    $display("[TB] watchdog");
    do_reset();
    pulse_fetch(64'h5000);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    for (int i = 0; i < TB_TIMEOUT; i++) applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    checkOutput("t5_timeout_err", timeout_err, 1);
    checkOutput("t5_no_done", n_if_done, 0);
    pulse_fetch(64'h9000);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 64'h1234);
    checkOutput("t5_later_done", n_if_done, 1);
    checkOutput("t5_later_rdata", if_rdata, 64'h1234);

    $display("[TB] reset during wait");
    do_reset();
    pulse_fetch(64'h6000);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    do_reset();
    applyStimulus(0, 1, 64'hBAD);
    applyStimulus(0, 0, '0);
    checkOutput("t6_no_done", n_if_done + n_d_done, 0);
    checkOutput("t6_req_valid", mem.req_valid, 0);

    $display("[TB] randomised traffic");
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) pulse_fetch({$urandom, $urandom});
      if ($urandom_range(5) == 0) pulse_data({$urandom, $urandom}, $urandom_range(1) == 1, {$urandom, $urandom}, 8'($urandom));
      applyStimulus($urandom_range(1) == 1, $urandom_range(2) == 0, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
